// File: rtl/av_common.sv
// ---------------------------------------------------------------------------
// av_common
// Shared Avalon-MM definitions for the burst master and its neighbours:
//   - response codes carried on av_response_i
//   - READ/WRITE operation encodings used on the command interface
//   - burst master state encoding
//   - a small helper that classifies a response code as an error
// ---------------------------------------------------------------------------
package av_common;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_SLAVEERROR  = 2'b10;
    localparam logic [1:0] RESP_DECODEERROR = 2'b11;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_DATA = 2'd3
    } burst_state_t;

    // Anything other than OKAY (including the reserved 01 code) is an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/av_burst_master.sv
// ---------------------------------------------------------------------------
// av_burst_master
// Turns one command (address, byteenable, beat count, direction) into a single
// Avalon-MM burst and reports completion with a one-cycle done pulse.
//
// Ports
//   av_clk_i, av_rst_i          clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o   command handshake (ready only while idle)
//   cmd_write_i                 1 = write burst, 0 = read burst
//   cmd_addr_i, cmd_be_i,
//   cmd_count_i                 burst start address, byteenable, beat count
//                               (count 0 runs as a single beat)
//   wdata_i / wdata_valid_i /
//   wdata_ready_o               write-data stream into the burst
//   rdata_o / rdata_valid_o /
//   rdata_last_o                registered read-data stream, no backpressure
//   done_o / done_err_o         completion pulse, error flag valid with it
//   av_*_o                      Avalon-MM master request signals
//   av_waitrequest_i, av_readdatavalid_i,
//   av_response_i, av_readdata_i  Avalon-MM slave response signals
// ---------------------------------------------------------------------------
module av_burst_master
    import av_common::*;
#(
    parameter int dw     = 32,
    parameter int aw     = 32,
    parameter int burstw = 8
) (
    input  logic                av_clk_i,
    input  logic                av_rst_i,

    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [aw-1:0]       cmd_addr_i,
    input  logic [dw/8-1:0]     cmd_be_i,
    input  logic [burstw-1:0]   cmd_count_i,

    input  logic [dw-1:0]       wdata_i,
    input  logic                wdata_valid_i,
    output logic                wdata_ready_o,

    output logic [dw-1:0]       rdata_o,
    output logic                rdata_valid_o,
    output logic                rdata_last_o,

    output logic                done_o,
    output logic                done_err_o,

    output logic [aw-1:0]       av_address_o,
    output logic [dw-1:0]       av_writedata_o,
    output logic [dw/8-1:0]     av_byteenable_o,
    output logic [burstw-1:0]   av_burstcount_o,
    output logic                av_write_o,
    output logic                av_read_o,

    input  logic                av_waitrequest_i,
    input  logic                av_readdatavalid_i,
    input  logic [1:0]          av_response_i,
    input  logic [dw-1:0]       av_readdata_i
);

    // The remaining-beat counter carries one spare bit so a full-size burst
    // (2^burstw-1 beats) never wraps.
    localparam logic [burstw:0]   REM_ONE   = {{burstw{1'b0}}, 1'b1};
    localparam logic [burstw-1:0] COUNT_ONE = {{(burstw-1){1'b0}}, 1'b1};

    burst_state_t        state_r;
    burst_state_t        state_s;

    logic [aw-1:0]       addr_r;
    logic [dw/8-1:0]     be_r;
    logic [burstw-1:0]   count_r;
    logic [burstw:0]     remaining_r;
    logic                err_r;

    logic                done_r;
    logic                done_err_r;
    logic [dw-1:0]       rdata_r;
    logic                rdata_valid_r;
    logic                rdata_last_r;

    logic                cmd_ready_s;
    logic                cmd_accept_s;
    logic [burstw-1:0]   cmd_count_s;
    logic                wr_beat_s;
    logic                rd_beat_s;
    logic                beat_s;
    logic                last_beat_s;
    logic                beat_err_s;

    // Command acceptance and beat qualification.
    always_comb begin
        cmd_ready_s  = (state_r == ST_IDLE) && !av_rst_i;
        cmd_accept_s = cmd_ready_s && cmd_valid_i;
        if (cmd_count_i == {burstw{1'b0}}) begin
            cmd_count_s = COUNT_ONE;
        end else begin
            cmd_count_s = cmd_count_i;
        end
        // A write beat moves only when data is offered and the slave takes it;
        // a master-side stall (wdata_valid_i low) does not count.
        wr_beat_s   = (state_r == ST_WR) && wdata_valid_i && !av_waitrequest_i;
        // Read data is honoured only while a read burst is collecting beats.
        rd_beat_s   = (state_r == ST_RD_DATA) && av_readdatavalid_i;
        beat_s      = wr_beat_s || rd_beat_s;
        last_beat_s = (remaining_r == REM_ONE);
        beat_err_s  = beat_s && resp_is_err(av_response_i);
    end

    // Next-state decode and Avalon request signals.
    always_comb begin
        state_s        = state_r;
        av_write_o     = 1'b0;
        av_read_o      = 1'b0;
        av_writedata_o = {dw{1'b0}};
        wdata_ready_o  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_accept_s) begin
                    if (cmd_write_i == OP_WRITE) begin
                        state_s = ST_WR;
                    end else begin
                        state_s = ST_RD_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR: begin
                av_write_o     = wdata_valid_i;
                av_writedata_o = wdata_i;
                wdata_ready_o  = !av_waitrequest_i;
                if (wr_beat_s && last_beat_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_RD_REQ: begin
                // One read command per burst, held until the slave accepts it.
                av_read_o = 1'b1;
                if (!av_waitrequest_i) begin
                    state_s = ST_RD_DATA;
                end else begin
                    state_s = ST_RD_REQ;
                end
            end
            ST_RD_DATA: begin
                if (rd_beat_s && last_beat_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RD_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Burst context, beat counter, error flag and registered status outputs.
    always_ff @(posedge av_clk_i) begin
        if (av_rst_i) begin
            state_r       <= ST_IDLE;
            addr_r        <= {aw{1'b0}};
            be_r          <= {(dw/8){1'b0}};
            count_r       <= {burstw{1'b0}};
            remaining_r   <= {(burstw+1){1'b0}};
            err_r         <= 1'b0;
            done_r        <= 1'b0;
            done_err_r    <= 1'b0;
            rdata_r       <= {dw{1'b0}};
            rdata_valid_r <= 1'b0;
            rdata_last_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            done_r        <= 1'b0;
            done_err_r    <= 1'b0;
            rdata_valid_r <= 1'b0;
            rdata_last_r  <= 1'b0;
            if (cmd_accept_s) begin
                addr_r      <= cmd_addr_i;
                be_r        <= cmd_be_i;
                count_r     <= cmd_count_s;
                remaining_r <= {1'b0, cmd_count_s};
                err_r       <= 1'b0;
            end else begin
                if (beat_s) begin
                    remaining_r <= remaining_r - REM_ONE;
                end
                // An error beat marks the burst but does not cut it short.
                if (beat_err_s) begin
                    err_r <= 1'b1;
                end
                if (rd_beat_s) begin
                    rdata_r       <= av_readdata_i;
                    rdata_valid_r <= 1'b1;
                    rdata_last_r  <= last_beat_s;
                end
                if (beat_s && last_beat_s) begin
                    done_r     <= 1'b1;
                    done_err_r <= err_r || beat_err_s;
                end
            end
        end
    end

    assign cmd_ready_o     = cmd_ready_s;
    assign av_address_o    = addr_r;
    assign av_byteenable_o = be_r;
    assign av_burstcount_o = count_r;
    assign rdata_o         = rdata_r;
    assign rdata_valid_o   = rdata_valid_r;
    assign rdata_last_o    = rdata_last_r;
    assign done_o          = done_r;
    assign done_err_o      = done_err_r;

endmodule

// File: doc/av_burst_master.md
AV_BURST_MASTER -- requirements
Module: av_burst_master

Interface
REQ-001 Parameter dw, 32, Avalon data width in bits (multiple of 8).
REQ-002 Parameter aw, 32, Avalon address width.
REQ-003 Parameter burstw, 8, burstcount width.
REQ-004 av_clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 av_rst_i  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake; transfer when both high.
REQ-007 cmd_write_i  input  1  1=write burst, 0=read burst.
REQ-008 cmd_addr_i / cmd_be_i / cmd_count_i  input  aw/dw/8/burstw  start address, byteenable, beat count.
REQ-009 wdata_i / wdata_valid_i / wdata_ready_o  in/in/out  dw/1/1  write-data stream; beat moves when valid and ready.
REQ-010 rdata_o / rdata_valid_o / rdata_last_o  out/out/out  dw/1/1  read-data stream, no backpressure.
REQ-011 done_o / done_err_o  output  1/1  one-cycle completion pulse; error flag valid with done_o.
REQ-012 av_address_o, av_writedata_o, av_byteenable_o, av_burstcount_o, av_write_o, av_read_o  output  aw/dw/dw/8/burstw/1/1  Avalon-MM master request.
REQ-013 av_waitrequest_i, av_readdatavalid_i, av_response_i[1:0], av_readdata_i[dw-1:0]  input  Avalon-MM slave response.

Function
REQ-014 States SHALL be IDLE, WR, RD_REQ, RD_DATA.
REQ-015 cmd_ready_o SHALL be high only in IDLE; on accept, address, be, count latched; count 0 SHALL be treated as 1.
REQ-016 IDLE->WR on accepted write command; IDLE->RD_REQ on accepted read command.
REQ-017 av_address_o, av_byteenable_o, av_burstcount_o SHALL hold the latched values constant for the whole burst.
REQ-018 WR: av_write_o = wdata_valid_i; av_writedata_o = wdata_i; wdata_ready_o = !av_waitrequest_i (combinational, WR only).
REQ-019 Write beat SHALL count when av_write_o and !av_waitrequest_i; master stall (wdata_valid_i low) SHALL NOT count.
REQ-020 WR->IDLE after final beat counted, done_o pulsed next cycle.
REQ-021 RD_REQ: av_read_o high for one command, held until !av_waitrequest_i; then ->RD_DATA; av_read_o low thereafter.
REQ-022 RD_DATA: each av_readdatavalid_i SHALL register rdata_o=av_readdata_i, rdata_valid_o=1 (latency one cycle) and decrement remaining count.
REQ-023 rdata_last_o SHALL accompany the final read beat; RD_DATA->IDLE with done_o in same cycle as last beat.
REQ-024 av_response_i != OKAY on any counted write beat or valid read beat SHALL set a per-burst error flag, cleared on next command accept, reported on done_err_o; burst SHALL still run to full count.
REQ-025 av_readdatavalid_i outside RD_DATA SHALL be ignored.
REQ-026 av_read_o and av_write_o SHALL never be high together.
REQ-027 Remaining-beat counter SHALL be burstw+1 bits wide, no wrap at maximum count 2^burstw-1.

Reset
REQ-028 Reset SHALL force IDLE, av_read_o=av_write_o=0, rdata_valid_o=rdata_last_o=done_o=done_err_o=0, counter and error flag 0, latched address/be/count 0.
REQ-029 Reset mid-burst SHALL abandon the burst without done_o; read beats arriving after reset SHALL be ignored.
REQ-030 cmd_ready_o SHALL be 0 during reset and 1 the cycle after release.

Structure
REQ-031 Response codes (OKAY=00, SLAVEERROR=10, DECODEERROR=11) and READ/WRITE op constants SHALL come from shared av_common.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 Write, addr 0x100, count 4, waitrequest low, wdata continuous -> av_write_o 4 cycles, address 0x100 constant, burstcount 4, done_o once, done_err_o 0.
REQ-034 Write count 3 with wdata_valid_i gap at beat 2 and waitrequest high 2 cycles at beat 1 -> exactly 3 beats counted, data order preserved.
REQ-035 Read addr 0x40, count 8, waitrequest high 3 cycles -> av_read_o held 4 cycles; 8 rdata_valid_o beats, rdata_last_o on 8th, done_o with it.
REQ-036 Read count 2, second beat response 10 -> both beats delivered, done_err_o 1; next command clears error.
REQ-037 Reset asserted after 2 of 4 read beats -> IDLE, no done_o, trailing readdatavalid ignored, new command accepted.
REQ-038 cmd_count_i 0 -> single-beat transfer, burstcount 1.
